// File: rtl/core2wb_pkg.sv
// Shared types for the core-to-Wishbone pipelined bridge.
// Latency: none (types only).
// Backpressure: n/a.
package core2wb_pkg;

    // IDLE: nothing granted; ACTIVE: requests in flight; FLUSH: watchdog drain.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2
    } core2wb_state_e;

endpackage

// File: rtl/core2wb_if.sv
// Bundle of the core request/response port and the pipelined Wishbone B4 master port.
// Latency: none (wires only).
// Backpressure: core side via gnt, bus side via wb_stall_i; master = bridge, slave = core + bus.
interface core2wb_if #(
    parameter int AW = 28,
    parameter int DW = 32
);
    localparam int SEL_W = DW / 8;

    // core side
    logic             core_req_i;
    logic             core_gnt_o;
    logic             core_rvalid_o;
    logic             core_we_i;
    logic [SEL_W-1:0] core_be_i;
    logic [31:0]      core_addr_i;
    logic [DW-1:0]    core_wdata_i;
    logic [DW-1:0]    core_rdata_o;
    logic             core_err_o;

    // wishbone side
    logic [AW-1:0]    wb_adr_o;
    logic             wb_cyc_o;
    logic             wb_stb_o;
    logic             wb_we_o;
    logic [SEL_W-1:0] wb_sel_o;
    logic [DW-1:0]    wb_dat_m_o;
    logic             wb_stall_i;
    logic             wb_ack_i;
    logic             wb_err_i;
    logic [DW-1:0]    wb_dat_s_i;

    modport master (
        input  core_req_i, core_we_i, core_be_i, core_addr_i, core_wdata_i,
        input  wb_stall_i, wb_ack_i, wb_err_i, wb_dat_s_i,
        output core_gnt_o, core_rvalid_o, core_rdata_o, core_err_o,
        output wb_adr_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_dat_m_o
    );

    modport slave (
        output core_req_i, core_we_i, core_be_i, core_addr_i, core_wdata_i,
        output wb_stall_i, wb_ack_i, wb_err_i, wb_dat_s_i,
        input  core_gnt_o, core_rvalid_o, core_rdata_o, core_err_o,
        input  wb_adr_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_dat_m_o
    );
endinterface

// File: rtl/core2wb_req_hold.sv
// Stall hold register: captures a granted request the slave stalled and replays it until accepted.
// Latency: 0 cycles (live request passes through when nothing is held).
// Backpressure: hold_valid tells the owner to stop granting; drain clears it.
// Ports: clk/rst, load (capture live_req), drain (held request accepted),
//        live_req in, hold_valid out, bus_req out (held request if valid, else live_req).
module core2wb_req_hold #(
    parameter type req_t = logic
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic drain,
    input  req_t live_req,
    output logic hold_valid,
    output req_t bus_req
);

    req_t held;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid <= 1'b0;
        end else if (load) begin
            hold_valid <= 1'b1;
        end else if (drain) begin
            hold_valid <= 1'b0;
        end
    end

    // Payload needs no reset: it is only observed while hold_valid is set.
    always_ff @(posedge clk) begin
        if (load) begin
            held <= live_req;
        end
    end

    assign bus_req = hold_valid ? held : live_req;

endmodule

// File: rtl/core2wb_pipelined.sv
// Bridge from the Ibex request interface to a pipelined Wishbone B4 master, up to MAX_OUTSTANDING in flight.
// Latency: request on the bus in the grant cycle; rvalid in the ack/err cycle (rdata combinational).
// Backpressure: gnt withheld while a stalled request is held, at MAX_OUTSTANDING, or during FLUSH.
// Ports: clk, rst (sync, active-high), bus (core2wb_if.master: core_* request/response, wb_* master).
// Optional: define CORE2WB_TIMEOUT_EN to add a watchdog that flushes hung transactions with error responses.
module core2wb_pipelined
    import core2wb_pkg::*;
#(
    parameter int AW              = 28,
    parameter int DW              = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic      clk,
    input  logic      rst,
    core2wb_if.master bus
);

    localparam int SEL_W    = DW / 8;
    localparam int ADDR_LSB = $clog2(SEL_W);
    localparam int CW       = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
    localparam logic [31:0] ADDR_USED = ((32'h1 << AW) - 32'h1) << ADDR_LSB;

    typedef struct packed {
        logic             we;
        logic [SEL_W-1:0] sel;
        logic [AW-1:0]    adr;
        logic [DW-1:0]    dat;
    } hold_req_t;

    core2wb_state_e state, state_nxt;
    logic [CW-1:0]  pend_cnt, pend_nxt, acc_cnt, acc_after_resp;
    logic           hold_valid, flushing, has_acc;
    logic           grant, stb, accept, response, timeout;
    hold_req_t      live_req, bus_req;

    // Byte address bits outside the word address are don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^(bus.core_addr_i & ~ADDR_USED);

    assign flushing = (state == FLUSH);

    // Held request counts as pending but has not reached the slave yet.
    assign acc_cnt = pend_cnt - CW'(hold_valid);
    assign has_acc = (acc_cnt != '0);

    assign grant = bus.core_req_i & ~hold_valid & (pend_cnt < MAX_CNT) & ~flushing & ~rst;

    assign live_req.we  = bus.core_we_i;
    assign live_req.sel = bus.core_we_i ? bus.core_be_i : '1;
    assign live_req.adr = bus.core_addr_i[AW+ADDR_LSB-1:ADDR_LSB];
    assign live_req.dat = bus.core_wdata_i;

    core2wb_req_hold #(.req_t(hold_req_t)) u_hold (
        .clk        (clk),
        .rst        (rst),
        .load       (grant & bus.wb_stall_i),
        .drain      (hold_valid & accept),
        .live_req   (live_req),
        .hold_valid (hold_valid),
        .bus_req    (bus_req)
    );

    // Held request is parked (stb low) during FLUSH and re-issued afterwards.
    assign stb    = (grant | hold_valid) & ~flushing & ~rst;
    assign accept = stb & ~bus.wb_stall_i;

    // In FLUSH the slave is ignored and one error response is forced per cycle.
    assign response = ~rst & has_acc &
                      (flushing | bus.wb_ack_i | bus.wb_err_i);

    assign bus.core_gnt_o    = grant;
    assign bus.core_rvalid_o = response;
    assign bus.core_err_o    = response & (flushing | bus.wb_err_i);
    assign bus.core_rdata_o  = bus.wb_dat_s_i;

    assign bus.wb_stb_o   = stb;
    assign bus.wb_cyc_o   = ~rst & ~flushing & (stb | (pend_cnt != '0));
    assign bus.wb_we_o    = bus_req.we;
    assign bus.wb_sel_o   = bus_req.sel;
    assign bus.wb_adr_o   = bus_req.adr;
    assign bus.wb_dat_m_o = bus_req.dat;

    assign pend_nxt       = pend_cnt + CW'(grant) - CW'(response);
    assign acc_after_resp = acc_cnt - CW'(response);

`ifdef CORE2WB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            wd_clear;

    // Only counts while accepted transactions sit unanswered with no bus progress.
    assign wd_clear = response | accept | ~has_acc | (state != ACTIVE);
    assign timeout  = ~wd_clear & (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || wd_clear || timeout) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant) state_nxt = ACTIVE;
            end
            ACTIVE: begin
                if (timeout)              state_nxt = FLUSH;
                else if (pend_nxt == '0)  state_nxt = IDLE;
            end
            FLUSH: begin
                if (acc_after_resp == '0) state_nxt = hold_valid ? ACTIVE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pend_cnt <= '0;
        end else begin
            state    <= state_nxt;
            pend_cnt <= pend_nxt;
        end
    end

endmodule

// File: tb/tb_core2wb_pipelined.sv
// Directed bench for core2wb_pipelined: reset, single read, pipelined writes, stall hold, error, spurious ack, timeout flush.
// Inputs change 1 time unit after posedge, outputs sampled at negedge.
// Expected values are hand-derived per scenario.
module tb_core2wb_pipelined;
    import core2wb_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    core2wb_if #(.AW(28), .DW(32)) bus ();

    core2wb_pipelined #(
        .AW(28), .DW(32), .MAX_OUTSTANDING(2), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.core_req_i   = 1'b0;
        bus.core_we_i    = 1'b0;
        bus.core_be_i    = 4'h0;
        bus.core_addr_i  = 32'h0;
        bus.core_wdata_i = 32'h0;
        bus.wb_stall_i   = 1'b0;
        bus.wb_ack_i     = 1'b0;
        bus.wb_err_i     = 1'b0;
        bus.wb_dat_s_i   = 32'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        bus.core_req_i = 1'b1;
        bus.wb_ack_i   = 1'b1;
        tick();
        @(negedge clk);
        n_cmp++; if (bus.core_gnt_o !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %b want 0", bus.core_gnt_o); end
        n_cmp++; if (bus.wb_stb_o !== 1'b0) begin n_fail++; $display("FAIL reset_stb: got %b want 0", bus.wb_stb_o); end
        n_cmp++; if (bus.wb_cyc_o !== 1'b0) begin n_fail++; $display("FAIL reset_cyc: got %b want 0", bus.wb_cyc_o); end
        n_cmp++; if (bus.core_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b want 0", bus.core_rvalid_o); end
        tick();
        idle_inputs();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (dut.pend_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_pend: got %0d want 0", dut.pend_cnt); end
        n_cmp++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", dut.state); end
        tick();
    endtask

    task automatic test_single_read();
        bus.core_req_i  = 1'b1;
        bus.core_we_i   = 1'b0;
        bus.core_be_i   = 4'h0;
        bus.core_addr_i = 32'h0000_0010;
        @(negedge clk);
        n_cmp++; if (bus.core_gnt_o !== 1'b1) begin n_fail++; $display("FAIL rd_gnt: got %b want 1", bus.core_gnt_o); end
        n_cmp++; if (bus.wb_stb_o !== 1'b1) begin n_fail++; $display("FAIL rd_stb: got %b want 1", bus.wb_stb_o); end
        n_cmp++; if (bus.wb_adr_o !== 28'h4) begin n_fail++; $display("FAIL rd_adr: got %h want 4", bus.wb_adr_o); end
        n_cmp++; if (bus.wb_sel_o !== 4'hF) begin n_fail++; $display("FAIL rd_sel: got %h want F", bus.wb_sel_o); end
        n_cmp++; if (bus.wb_we_o !== 1'b0) begin n_fail++; $display("FAIL rd_we: got %b want 0", bus.wb_we_o); end
        n_cmp++; if (bus.core_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rd_rvalid0: got %b want 0", bus.core_rvalid_o); end
        tick();
        bus.core_req_i = 1'b0;
        bus.wb_ack_i   = 1'b1;
        bus.wb_dat_s_i = 32'hDEAD_BEEF;
        @(negedge clk);
        n_cmp++; if (bus.core_rvalid_o !== 1'b1) begin n_fail++; $display("FAIL rd_rvalid1: got %b want 1", bus.core_rvalid_o); end
        n_cmp++; if (bus.core_rdata_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_rdata: got %h want DEADBEEF", bus.core_rdata_o); end
        n_cmp++; if (bus.core_err_o !== 1'b0) begin n_fail++; $display("FAIL rd_err: got %b want 0", bus.core_err_o); end
        n_cmp++; if (bus.wb_stb_o !== 1'b0) begin n_fail++; $display("FAIL rd_stb1: got %b want 0", bus.wb_stb_o); end
        tick();
        idle_inputs();
        @(negedge clk);
        n_cmp++; if (bus.wb_cyc_o !== 1'b0) begin n_fail++; $display("FAIL rd_cyc_end: got %b want 0", bus.wb_cyc_o); end
        n_cmp++; if (bus.core_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rd_rvalid2: got %b want 0", bus.core_rvalid_o); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic req_v  [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic ack_v  [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic gnt_e  [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic rv_e   [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic cyc_e  [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int   idx      = 0;
        int   max_pend = 0;
        for (int c = 0; c < 9; c++) begin
            bus.core_req_i   = req_v[c];
            bus.core_we_i    = 1'b1;
            bus.core_be_i    = 4'hF;
            bus.core_addr_i  = 32'h100 + 32'(idx * 4);
            bus.core_wdata_i = 32'h1111_0000 + 32'(idx);
            bus.wb_ack_i     = ack_v[c];
            @(negedge clk);
            n_cmp++; if (bus.core_gnt_o !== gnt_e[c]) begin n_fail++; $display("FAIL b2b_gnt c%0d: got %b want %b", c, bus.core_gnt_o, gnt_e[c]); end
            n_cmp++; if (bus.core_rvalid_o !== rv_e[c]) begin n_fail++; $display("FAIL b2b_rvalid c%0d: got %b want %b", c, bus.core_rvalid_o, rv_e[c]); end
            n_cmp++; if (bus.wb_cyc_o !== cyc_e[c]) begin n_fail++; $display("FAIL b2b_cyc c%0d: got %b want %b", c, bus.wb_cyc_o, cyc_e[c]); end
            if (gnt_e[c]) begin
                n_cmp++; if (bus.wb_adr_o !== 28'h40 + 28'(idx)) begin n_fail++; $display("FAIL b2b_adr c%0d: got %h want %h", c, bus.wb_adr_o, 28'h40 + 28'(idx)); end
                n_cmp++; if (bus.wb_dat_m_o !== 32'h1111_0000 + 32'(idx)) begin n_fail++; $display("FAIL b2b_dat c%0d: got %h want %h", c, bus.wb_dat_m_o, 32'h1111_0000 + 32'(idx)); end
                n_cmp++; if (bus.wb_we_o !== 1'b1) begin n_fail++; $display("FAIL b2b_we c%0d: got %b want 1", c, bus.wb_we_o); end
                idx++;
            end
            if (int'(dut.pend_cnt) > max_pend) max_pend = int'(dut.pend_cnt);
            tick();
        end
        n_cmp++; if (max_pend != 2) begin n_fail++; $display("FAIL b2b_max_pend: got %0d want 2", max_pend); end
        idle_inputs();
    endtask

    task automatic test_stall();
        bus.core_req_i   = 1'b1;
        bus.core_we_i    = 1'b1;
        bus.core_be_i    = 4'b0011;
        bus.core_addr_i  = 32'h0000_0020;
        bus.core_wdata_i = 32'hCAFE_0001;
        bus.wb_stall_i   = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                // Core moves on to a different request; it must not be granted.
                bus.core_we_i    = 1'b0;
                bus.core_be_i    = 4'hF;
                bus.core_addr_i  = 32'h0000_0040;
                bus.core_wdata_i = 32'h5555_5555;
            end
            if (c == 4) begin
                bus.wb_stall_i = 1'b0;
                bus.core_req_i = 1'b0;
            end
            @(negedge clk);
            n_cmp++; if (bus.core_gnt_o !== (c == 0)) begin n_fail++; $display("FAIL stall_gnt c%0d: got %b want %b", c, bus.core_gnt_o, c == 0); end
            n_cmp++; if (bus.wb_stb_o !== 1'b1) begin n_fail++; $display("FAIL stall_stb c%0d: got %b want 1", c, bus.wb_stb_o); end
            n_cmp++; if (bus.wb_adr_o !== 28'h8) begin n_fail++; $display("FAIL stall_adr c%0d: got %h want 8", c, bus.wb_adr_o); end
            n_cmp++; if (bus.wb_sel_o !== 4'b0011) begin n_fail++; $display("FAIL stall_sel c%0d: got %h want 3", c, bus.wb_sel_o); end
            n_cmp++; if (bus.wb_dat_m_o !== 32'hCAFE_0001) begin n_fail++; $display("FAIL stall_dat c%0d: got %h want CAFE0001", c, bus.wb_dat_m_o); end
            n_cmp++; if (bus.wb_we_o !== 1'b1) begin n_fail++; $display("FAIL stall_we c%0d: got %b want 1", c, bus.wb_we_o); end
            n_cmp++; if (bus.core_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL stall_rvalid c%0d: got %b want 0", c, bus.core_rvalid_o); end
            tick();
        end
        bus.wb_ack_i = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.wb_stb_o !== 1'b0) begin n_fail++; $display("FAIL stall_stb_after: got %b want 0", bus.wb_stb_o); end
        n_cmp++; if (bus.core_rvalid_o !== 1'b1) begin n_fail++; $display("FAIL stall_rvalid_ack: got %b want 1", bus.core_rvalid_o); end
        tick();
        idle_inputs();
        @(negedge clk);
        n_cmp++; if (bus.wb_cyc_o !== 1'b0) begin n_fail++; $display("FAIL stall_cyc_end: got %b want 0", bus.wb_cyc_o); end
        tick();
    endtask

    task automatic test_error();
        bus.core_req_i  = 1'b1;
        bus.core_addr_i = 32'h0000_0030;
        @(negedge clk);
        n_cmp++; if (bus.core_gnt_o !== 1'b1) begin n_fail++; $display("FAIL err_gnt0: got %b want 1", bus.core_gnt_o); end
        tick();
        bus.core_addr_i = 32'h0000_0034;
        @(negedge clk);
        n_cmp++; if (bus.core_gnt_o !== 1'b1) begin n_fail++; $display("FAIL err_gnt1: got %b want 1", bus.core_gnt_o); end
        n_cmp++; if (bus.wb_adr_o !== 28'hD) begin n_fail++; $display("FAIL err_adr1: got %h want D", bus.wb_adr_o); end
        tick();
        bus.core_req_i = 1'b0;
        bus.wb_ack_i   = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.core_rvalid_o !== 1'b1) begin n_fail++; $display("FAIL err_rv0: got %b want 1", bus.core_rvalid_o); end
        n_cmp++; if (bus.core_err_o !== 1'b0) begin n_fail++; $display("FAIL err_err0: got %b want 0", bus.core_err_o); end
        tick();
        bus.wb_ack_i = 1'b0;
        bus.wb_err_i = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.core_rvalid_o !== 1'b1) begin n_fail++; $display("FAIL err_rv1: got %b want 1", bus.core_rvalid_o); end
        n_cmp++; if (bus.core_err_o !== 1'b1) begin n_fail++; $display("FAIL err_err1: got %b want 1", bus.core_err_o); end
        tick();
        idle_inputs();
        @(negedge clk);
        n_cmp++; if (bus.wb_cyc_o !== 1'b0) begin n_fail++; $display("FAIL err_cyc_end: got %b want 0", bus.wb_cyc_o); end
        tick();
    endtask

    task automatic test_spurious_and_reset();
        bus.wb_ack_i = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.core_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL spur_rvalid: got %b want 0", bus.core_rvalid_o); end
        n_cmp++; if (bus.wb_cyc_o !== 1'b0) begin n_fail++; $display("FAIL spur_cyc: got %b want 0", bus.wb_cyc_o); end
        tick();
        bus.wb_ack_i    = 1'b0;
        bus.core_req_i  = 1'b1;
        bus.core_addr_i = 32'h0000_0050;
        @(negedge clk);
        n_cmp++; if (bus.core_gnt_o !== 1'b1) begin n_fail++; $display("FAIL mid_gnt: got %b want 1", bus.core_gnt_o); end
        tick();
        rst            = 1'b1;
        bus.core_req_i = 1'b1;
        bus.wb_ack_i   = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.wb_cyc_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_cyc: got %b want 0", bus.wb_cyc_o); end
        n_cmp++; if (bus.core_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_rvalid: got %b want 0", bus.core_rvalid_o); end
        n_cmp++; if (bus.core_gnt_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_gnt: got %b want 0", bus.core_gnt_o); end
        tick();
        rst            = 1'b0;
        bus.core_req_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (dut.pend_cnt !== 2'd0) begin n_fail++; $display("FAIL post_rst_pend: got %0d want 0", dut.pend_cnt); end
        n_cmp++; if (bus.core_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL post_rst_rvalid: got %b want 0", bus.core_rvalid_o); end
        n_cmp++; if (bus.wb_cyc_o !== 1'b0) begin n_fail++; $display("FAIL post_rst_cyc: got %b want 0", bus.wb_cyc_o); end
        n_cmp++; if (bus.wb_stb_o !== 1'b0) begin n_fail++; $display("FAIL post_rst_stb: got %b want 0", bus.wb_stb_o); end
        tick();
        idle_inputs();
    endtask

`ifdef CORE2WB_TIMEOUT_EN
    task automatic test_timeout();
        logic seen = 1'b0;
        int   waited = 0;
        bus.core_req_i  = 1'b1;
        bus.core_addr_i = 32'h0000_0060;
        tick();
        bus.core_addr_i = 32'h0000_0064;
        tick();
        bus.core_req_i = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.wb_cyc_o === 1'b0) seen = 1'b1;
            else begin
                waited++;
                tick();
            end
        end
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL to_cyc_drop: got cyc=1 after 40 cycles want 0"); end
        n_cmp++; if (waited != 16) begin n_fail++; $display("FAIL to_wait: got %0d cycles want 16", waited); end
        n_cmp++; if ({bus.core_rvalid_o, bus.core_err_o} !== 2'b11) begin n_fail++; $display("FAIL to_resp0: got %b want 11", {bus.core_rvalid_o, bus.core_err_o}); end
        tick();
        @(negedge clk);
        n_cmp++; if ({bus.core_rvalid_o, bus.core_err_o} !== 2'b11) begin n_fail++; $display("FAIL to_resp1: got %b want 11", {bus.core_rvalid_o, bus.core_err_o}); end
        tick();
        bus.core_req_i  = 1'b1;
        bus.core_addr_i = 32'h0000_0070;
        @(negedge clk);
        n_cmp++; if (bus.core_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL to_resp2: got %b want 0", bus.core_rvalid_o); end
        n_cmp++; if (bus.core_gnt_o !== 1'b1) begin n_fail++; $display("FAIL to_regrant: got %b want 1", bus.core_gnt_o); end
        tick();
        bus.core_req_i = 1'b0;
        bus.wb_ack_i   = 1'b1;
        @(negedge clk);
        n_cmp++; if ({bus.core_rvalid_o, bus.core_err_o} !== 2'b10) begin n_fail++; $display("FAIL to_after_ack: got %b want 10", {bus.core_rvalid_o, bus.core_err_o}); end
        tick();
        idle_inputs();
    endtask
`endif

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        idle_inputs();
        test_reset();
        test_single_read();
        test_back_to_back();
        test_stall();
        test_error();
        test_spurious_and_reset();
`ifdef CORE2WB_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
